// File: rtl/e203_wfi_ctrl.sv
// ---------------------------------------------------------------------------
// e203_wfi_ctrl
// Sequences a WFI instruction: drain the pipeline, sleep, wake up, and hand
// control back to commit with a single wfi_ack pulse.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wfi_req           1-cycle pulse from commit when a WFI retires
//   dbg_mode          debug mode; a WFI then behaves as a NOP
//   irq_pending       enabled external/software/timer interrupt pending
//   dbg_irq           debug halt request
//   oitf_empty,
//   lsu_idle,
//   biu_idle          pipeline-drain qualifiers
//   core_wfi          sleep indication for clock-gate enables (SLEEP only)
//   halt_ifu          stops instruction fetch (DRAIN, SLEEP, WAKE)
//   wfi_ack           1-cycle pulse when the WFI completes
//   drain_timeout     sticky, set when a drain gives up
//   sleep_cnt[15:0]   cycles spent in the last or current SLEEP, saturating
//   fsm_state[1:0]    current state (0 RUN, 1 DRAIN, 2 SLEEP, 3 WAKE)
//
// Handshake: wfi_req is accepted only in RUN while wfi_ack is low; every
// accepted wfi_req yields exactly one wfi_ack, and acks are never adjacent.
// ---------------------------------------------------------------------------
module e203_wfi_ctrl #(
   parameter int unsigned DRAIN_TO = 64,
   parameter int unsigned WAKE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wfi_req,
   input  logic        dbg_mode,
   input  logic        irq_pending,
   input  logic        dbg_irq,
   input  logic        oitf_empty,
   input  logic        lsu_idle,
   input  logic        biu_idle,
   output logic        core_wfi,
   output logic        halt_ifu,
   output logic        wfi_ack,
   output logic        drain_timeout,
   output logic [15:0] sleep_cnt,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } state_e;

   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TO - 1);
   localparam logic [3:0] WAKE_LOAD  = 4'(WAKE_CYC);

   state_e      state_q, state_d;
   logic [7:0]  drain_cnt_q, drain_cnt_d;
   logic [3:0]  wake_cnt_q, wake_cnt_d;
   logic [15:0] sleep_cnt_q, sleep_cnt_d;
   logic        ack_q, ack_d;
   logic        timeout_q, timeout_d;
   logic        core_wfi_q, halt_q;

   logic wake, drained;
   assign wake    = irq_pending | dbg_irq;
   assign drained = oitf_empty & lsu_idle & biu_idle;

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      wake_cnt_d  = wake_cnt_q;
      sleep_cnt_d = sleep_cnt_q;
      ack_d       = 1'b0;
      timeout_d   = timeout_q;
      case (state_q)
         ST_RUN: begin
            // A request coinciding with our own ack is not accepted, which
            // keeps acks from landing in consecutive cycles.
            if (wfi_req && !ack_q) begin
               if (wake || dbg_mode) begin
                  ack_d = 1'b1;
               end else begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = 8'd0;
               end
            end
         end
         ST_DRAIN: begin
            // Wake wins over a drained pipeline in the same cycle.
            if (wake) begin
               state_d = ST_RUN;
               ack_d   = 1'b1;
            end else if (drained) begin
               state_d     = ST_SLEEP;
               sleep_cnt_d = 16'd0;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               state_d   = ST_RUN;
               ack_d     = 1'b1;
               timeout_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 8'd1;
            end
         end
         ST_SLEEP: begin
            // Qualifiers may drop here (TCM access by other masters); only
            // wake leaves SLEEP.
            if (sleep_cnt_q != 16'hFFFF) sleep_cnt_d = sleep_cnt_q + 16'd1;
            if (wake) begin
               state_d    = ST_WAKE;
               wake_cnt_d = WAKE_LOAD;
            end
         end
         ST_WAKE: begin
            // Runs to completion regardless of wake.
            if (wake_cnt_q <= 4'd1) begin
               state_d    = ST_RUN;
               ack_d      = 1'b1;
               wake_cnt_d = 4'd0;
            end else begin
               wake_cnt_d = wake_cnt_q - 4'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= 8'd0;
         wake_cnt_q  <= 4'd0;
         sleep_cnt_q <= 16'd0;
         ack_q       <= 1'b0;
         timeout_q   <= 1'b0;
         core_wfi_q  <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         wake_cnt_q  <= wake_cnt_d;
         sleep_cnt_q <= sleep_cnt_d;
         ack_q       <= ack_d;
         timeout_q   <= timeout_d;
         core_wfi_q  <= (state_d == ST_SLEEP);
         halt_q      <= (state_d != ST_RUN);
      end
   end

   assign core_wfi      = core_wfi_q;
   assign halt_ifu      = halt_q;
   assign wfi_ack       = ack_q;
   assign drain_timeout = timeout_q;
   assign sleep_cnt     = sleep_cnt_q;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_e203_wfi_ctrl.sv
module tb_e203_wfi_ctrl;

   logic        clk, rst_n;
   logic        wfi_req, dbg_mode, irq_pending, dbg_irq;
   logic        oitf_empty, lsu_idle, biu_idle;
   logic        core_wfi, halt_ifu, wfi_ack, drain_timeout;
   logic [15:0] sleep_cnt;
   logic [1:0]  fsm_state;

   localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_SLEEP = 2'd2, S_WAKE = 2'd3;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_sleep = 16'd0;

   // {halt_ifu, core_wfi, drain_timeout, sleep_cnt} expected at each wfi_ack
   logic [18:0] exp_q[$];
   logic        prev_ack;

   e203_wfi_ctrl #(.DRAIN_TO(64), .WAKE_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .wfi_req(wfi_req), .dbg_mode(dbg_mode),
      .irq_pending(irq_pending), .dbg_irq(dbg_irq), .oitf_empty(oitf_empty),
      .lsu_idle(lsu_idle), .biu_idle(biu_idle), .core_wfi(core_wfi),
      .halt_ifu(halt_ifu), .wfi_ack(wfi_ack), .drain_timeout(drain_timeout),
      .sleep_cnt(sleep_cnt), .fsm_state(fsm_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sat16(int n);
      return (n >= 65535) ? 16'hFFFF : 16'(n);
   endfunction

   // scoreboard: pop one expectation per wfi_ack
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ack <= 1'b0;
      end else begin
         if (wfi_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL ack_unexpected: got wfi_ack=1 required no ack at %0t", $time);
            end else begin
               logic [18:0] e;
               e = exp_q.pop_front();
               if ({halt_ifu, core_wfi, drain_timeout, sleep_cnt} !== e)
                  $display("FAIL ack_outputs: got %05h required %05h at %0t",
                           {halt_ifu, core_wfi, drain_timeout, sleep_cnt}, e, $time);
               else n_pass++;
            end
            n_checks++;
            if (prev_ack !== 1'b0)
               $display("FAIL ack_adjacent: got two adjacent acks required one at %0t", $time);
            else n_pass++;
         end
         prev_ack <= wfi_ack;
      end
   end

   // driver tasks
   task automatic test_reset();
      n_checks++;
      if ({core_wfi, halt_ifu, wfi_ack, drain_timeout, sleep_cnt, fsm_state} !== 22'd0)
         $display("FAIL reset_values: got %06h required 000000",
                  {core_wfi, halt_ifu, wfi_ack, drain_timeout, sleep_cnt, fsm_state});
      else n_pass++;
   endtask

   task automatic test_normal_sleep(input int n, input logic dt);
      int err;
      err = 0;
      exp_sleep = sat16(n);
      exp_q.push_back({2'b00, dt, exp_sleep});
      wfi_req = 1'b1;
      step();
      wfi_req = 1'b0;
      n_checks++;
      if ({fsm_state, halt_ifu, core_wfi} !== {S_DRAIN, 2'b10})
         $display("FAIL sleep_drain: got st=%0d halt=%b wfi=%b required st=1 halt=1 wfi=0",
                  fsm_state, halt_ifu, core_wfi);
      else n_pass++;
      step();
      for (int i = 1; i <= n; i++) begin
         if (core_wfi !== 1'b1 || fsm_state !== S_SLEEP || sleep_cnt !== sat16(i - 1)) err++;
         if (i == n) irq_pending = 1'b1;
         step();
      end
      n_checks++;
      if (err != 0) $display("FAIL sleep_hold: got %0d bad cycles required 0", err);
      else n_pass++;
      irq_pending = 1'b0;
      n_checks++;
      if ({fsm_state, core_wfi, halt_ifu, sleep_cnt} !== {S_WAKE, 2'b01, exp_sleep})
         $display("FAIL sleep_wake1: got st=%0d wfi=%b halt=%b cnt=%0h required st=3 wfi=0 halt=1 cnt=%0h",
                  fsm_state, core_wfi, halt_ifu, sleep_cnt, exp_sleep);
      else n_pass++;
      step();
      n_checks++;
      if ({fsm_state, core_wfi, halt_ifu, wfi_ack} !== {S_WAKE, 3'b010})
         $display("FAIL sleep_wake2: got st=%0d wfi=%b halt=%b ack=%b required st=3 wfi=0 halt=1 ack=0",
                  fsm_state, core_wfi, halt_ifu, wfi_ack);
      else n_pass++;
      step();
      n_checks++;
      if ({fsm_state, halt_ifu, wfi_ack, drain_timeout} !== {S_RUN, 2'b01, dt})
         $display("FAIL sleep_done: got st=%0d halt=%b ack=%b dto=%b required st=0 halt=0 ack=1 dto=%b",
                  fsm_state, halt_ifu, wfi_ack, drain_timeout, dt);
      else n_pass++;
      step();
   endtask

   task automatic test_pending_wake(input logic use_dbg);
      if (use_dbg) dbg_mode = 1'b1; else irq_pending = 1'b1;
      exp_q.push_back({2'b00, drain_timeout, exp_sleep});
      wfi_req = 1'b1;
      step();
      wfi_req = 1'b0;
      n_checks++;
      if ({fsm_state, halt_ifu, core_wfi, wfi_ack} !== {S_RUN, 3'b001})
         $display("FAIL pending_%0s: got st=%0d halt=%b wfi=%b ack=%b required st=0 halt=0 wfi=0 ack=1",
                  use_dbg ? "dbg" : "irq", fsm_state, halt_ifu, core_wfi, wfi_ack);
      else n_pass++;
      dbg_mode = 1'b0;
      irq_pending = 1'b0;
      step();
      n_checks++;
      if ({fsm_state, halt_ifu, wfi_ack} !== {S_RUN, 2'b00})
         $display("FAIL pending_after: got st=%0d halt=%b ack=%b required st=0 halt=0 ack=0",
                  fsm_state, halt_ifu, wfi_ack);
      else n_pass++;
      step();
   endtask

   task automatic test_simultaneous();
      int extra;
      biu_idle = 1'b0;
      exp_q.push_back({2'b00, drain_timeout, exp_sleep});
      wfi_req = 1'b1;
      step();
      wfi_req = 1'b0;
      extra = $urandom_range(1, 4);
      for (int i = 0; i < extra; i++) begin
         wfi_req = (i == 0);   // ignored outside RUN
         step();
      end
      wfi_req = 1'b0;
      n_checks++;
      if (fsm_state !== S_DRAIN)
         $display("FAIL simul_drain: got st=%0d required st=1", fsm_state);
      else n_pass++;
      biu_idle = 1'b1;
      dbg_irq  = 1'b1;
      step();
      dbg_irq = 1'b0;
      n_checks++;
      if ({fsm_state, core_wfi, halt_ifu, wfi_ack} !== {S_RUN, 3'b001})
         $display("FAIL simul_wake: got st=%0d wfi=%b halt=%b ack=%b required st=0 wfi=0 halt=0 ack=1",
                  fsm_state, core_wfi, halt_ifu, wfi_ack);
      else n_pass++;
      step();
      step();
   endtask

   task automatic test_drain_timeout();
      int cnt;
      biu_idle = 1'b0;
      exp_q.push_back({2'b00, 1'b1, exp_sleep});
      wfi_req = 1'b1;
      step();
      wfi_req = 1'b0;
      cnt = 0;
      while (fsm_state == S_DRAIN && cnt < 300) begin
         cnt++;
         wfi_req = (cnt == 5);   // ignored outside RUN
         step();
      end
      wfi_req = 1'b0;
      biu_idle = 1'b1;
      n_checks++;
      if (cnt != 64) $display("FAIL timeout_len: got %0d drain cycles required 64", cnt);
      else n_pass++;
      n_checks++;
      if ({fsm_state, wfi_ack, drain_timeout, core_wfi} !== {S_RUN, 3'b110})
         $display("FAIL timeout_exit: got st=%0d ack=%b dto=%b wfi=%b required st=0 ack=1 dto=1 wfi=0",
                  fsm_state, wfi_ack, drain_timeout, core_wfi);
      else n_pass++;
      step();
      step();
   endtask

   task automatic test_reset_mid();
      wfi_req = 1'b1;
      step();
      wfi_req = 1'b0;
      step();
      step();
      step();
      n_checks++;
      if (fsm_state !== S_SLEEP) $display("FAIL rstmid_sleep: got st=%0d required st=2", fsm_state);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({core_wfi, halt_ifu, wfi_ack, drain_timeout, fsm_state} !== 6'd0)
         $display("FAIL rstmid_async: got %02h required 00",
                  {core_wfi, halt_ifu, wfi_ack, drain_timeout, fsm_state});
      else n_pass++;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if ({fsm_state, halt_ifu, sleep_cnt} !== {S_RUN, 1'b0, 16'd0})
         $display("FAIL rstmid_after: got st=%0d halt=%b cnt=%0h required st=0 halt=0 cnt=0",
                  fsm_state, halt_ifu, sleep_cnt);
      else n_pass++;
      exp_sleep = 16'd0;
   endtask

   initial begin
      rst_n = 1'b0;
      wfi_req = 1'b0; dbg_mode = 1'b0; irq_pending = 1'b0; dbg_irq = 1'b0;
      oitf_empty = 1'b1; lsu_idle = 1'b1; biu_idle = 1'b1;
      step();
      step();
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      test_normal_sleep(10, 1'b0);
      test_pending_wake(1'b0);
      test_pending_wake(1'b1);
      test_simultaneous();
      test_drain_timeout();
      test_normal_sleep($urandom_range(3, 8), 1'b1);
      test_normal_sleep(70000, 1'b1);
      test_reset_mid();
      test_normal_sleep(2, 1'b0);
      for (int i = 0; i < 5; i++) step();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL ack_missing: got %0d outstanding required 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/e203_wfi_ctrl.md
E203_WFI_CTRL -- requirements
Module: e203_wfi_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TO, default 64, meaning the maximum number of DRAIN cycles before the WFI is aborted (range 1..255).
REQ-002 SHALL have parameter WAKE_CYC, default 2, meaning the number of WAKE cycles after core_wfi drops before fetch resumes (range 1..15).
REQ-003 SHALL have port clk input 1: the single clock of this block; all state changes on its rising edge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-005 SHALL have port wfi_req input 1: single-cycle pulse from commit when a WFI instruction retires.
REQ-006 SHALL have port dbg_mode input 1: core is in debug mode; while high, a WFI executes as a NOP.
REQ-007 SHALL have port irq_pending input 1: OR of enabled external, software and timer interrupts.
REQ-008 SHALL have port dbg_irq input 1: debug halt request.
REQ-009 SHALL have port oitf_empty, lsu_idle and biu_idle, each input 1: pipeline-drain qualifiers.
REQ-010 SHALL have port core_wfi output 1: sleep indication that drives clock-gate enable logic.
REQ-011 SHALL have port halt_ifu output 1: stops instruction fetch.
REQ-012 SHALL have port wfi_ack output 1: single-cycle pulse when the WFI completes, letting commit proceed.
REQ-013 SHALL have port drain_timeout output 1: sticky flag set on a DRAIN abort.
REQ-014 SHALL have port sleep_cnt output 16: cycles spent in the last or current SLEEP.

Function
REQ-015 SHALL implement the FSM states RUN, DRAIN, SLEEP and WAKE, with wake = irq_pending | dbg_irq.
REQ-016 SHALL make the RUN -> DRAIN transition on wfi_req & ~wake & ~dbg_mode.
REQ-017 SHALL stay in RUN on wfi_req & (wake | dbg_mode) and pulse wfi_ack on the next cycle.
REQ-018 SHALL ignore wfi_req in any state other than RUN.
REQ-019 SHALL drive halt_ifu = 1 in the DRAIN, SLEEP and WAKE states, and 0 in RUN.
REQ-020 SHALL, in DRAIN, load a drain counter with 0 on entry and increment it by 1 each cycle.
REQ-021 SHALL go DRAIN -> SLEEP when oitf_empty & lsu_idle & biu_idle are all high in the same cycle and wake is low.
REQ-022 SHALL go DRAIN -> RUN and pulse wfi_ack when wake is high in DRAIN; wake has priority over a drained condition in the same cycle.
REQ-023 SHALL, when the drain counter reaches DRAIN_TO-1 without draining, go to RUN, pulse wfi_ack and set drain_timeout.
REQ-024 SHALL hold drain_timeout set until reset; it is never cleared by a later successful WFI.
REQ-025 SHALL assert core_wfi = 1 in SLEEP only, registered (it is 1 in the first SLEEP cycle).
REQ-026 SHALL, in SLEEP, go to WAKE when wake is high.
REQ-027 SHALL keep SLEEP when the drain qualifiers deassert, since external agents may access the TCMs.
REQ-028 SHALL clear sleep_cnt to 0 on DRAIN -> SLEEP.
REQ-029 SHALL increment sleep_cnt by 1 each SLEEP cycle, including the first, saturating at 16'hFFFF without wrapping.
REQ-030 SHALL hold sleep_cnt in all other states.
REQ-031 SHALL, in WAKE, load a wake counter with WAKE_CYC on entry and decrement it each cycle.
REQ-032 SHALL, when the wake counter is 1, go WAKE -> RUN and pulse wfi_ack in the first RUN cycle.
REQ-033 SHALL drive core_wfi = 0 throughout WAKE.
REQ-034 SHALL ignore wake deassertion during WAKE; the sequence always completes.
REQ-035 SHALL produce exactly one wfi_ack per accepted wfi_req, and never two wfi_ack pulses in consecutive cycles.
REQ-036 SHALL keep the counter widths as follows: drain counter 8 bits, wake counter 4 bits, sleep_cnt 16 bits.

Reset
REQ-037 SHALL, on rst_n low, asynchronously force state to RUN; core_wfi, halt_ifu, wfi_ack and drain_timeout to 0; sleep_cnt to 16'h0000; and the internal counters to 0.
REQ-038 SHALL, on reset asserted in any state mid-operation, abort the sequence without a wfi_ack pulse.
REQ-039 SHALL make the first transition possible on the first rising clk edge after rst_n rises.

Verification
REQ-040 SHALL cover a normal sleep: wfi_req with the qualifiers high and wake low, then irq_pending after 10 cycles. Required response: DRAIN 1 cycle; core_wfi high 10 cycles; sleep_cnt = 10; halt_ifu low and wfi_ack pulse 2 cycles after core_wfi falls.
REQ-041 SHALL cover pending wake: wfi_req with irq_pending already high. Required response: no DRAIN; halt_ifu stays 0; wfi_ack the next cycle; core_wfi never rises.
REQ-042 SHALL cover drain timeout: wfi_req with biu_idle held low. Required response: after 64 DRAIN cycles, state RUN, one wfi_ack, drain_timeout = 1. A later successful WFI leaves drain_timeout = 1.
REQ-043 SHALL cover simultaneous events: in DRAIN, the qualifiers go high in the same cycle as dbg_irq. Required response: RUN and wfi_ack, no SLEEP, core_wfi stays 0.
REQ-044 SHALL cover saturation: hold SLEEP for 70000 cycles. Required response: sleep_cnt = 16'hFFFF.
REQ-045 SHALL cover reset mid-operation: drop rst_n in SLEEP. Required response: core_wfi and halt_ifu 0 immediately, no wfi_ack, state RUN after release.
